debug_mem_arbiter: RTL
======================

# debug_mem_arbiter

Shares one single-port synchronous memory (imem or dmem; one instance per memory) between the CPU core and the debug controller's one-cycle memory strobes. Debug strobes carry no backpressure, so the block buffers one debug access and round-robins it against CPU valid/ready requests. It returns read data to whichever side issued the access. It sits between the debug controller, the CPU fetch or load/store port, and the memory macro.

## Interface
Parameters:
- AW, 12, memory word-address width; byte address bits [AW+1:2] select the word.

Ports:
- cpu_clk  in  1  clock; all logic is on the rising edge.
- sys_rstn  in  1  reset, asynchronous, active-low.
- dbg_ce  in  1  one-cycle debug access strobe.
- dbg_we  in  1  write qualifier for dbg_ce.
- dbg_addr  in  32  debug byte address.
- dbg_wdata  in  32  debug write data.
- dbg_rdata  out  32  debug read data; valid while dbg_rdata_ready is high.
- dbg_rdata_ready  out  1  one-cycle pulse marking debug read data.
- dbg_overflow  out  1  sticky: a debug strobe was dropped.
- dbg_ovf_clr  in  1  clears dbg_overflow.
- dbg_busy  out  1  a debug access is pending.
- cpu_halted  in  1  while high, the CPU is never granted.
- cpu_req  in  1  CPU request valid.
- cpu_we  in  1  CPU write qualifier.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rdata  out  32  CPU read data.
- cpu_rvalid  out  1  CPU read data valid.
- mem_ce, mem_we  out  1  memory enables.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid one cycle after a read.

## Operation
- **Debug buffer.** dbg_ce latches {we, addr, wdata} into a one-entry pending register and sets pend_valid.
  - A debug access is never issued in the cycle its strobe arrives.
  - If dbg_ce arrives while pend_valid=1 and the pending entry is not issued that cycle: drop the new strobe and set dbg_overflow.
  - If the pending entry issues in the same cycle: latch the new strobe; no overflow.
- **dbg_overflow.** Cleared by dbg_ovf_clr. If a set and a clear coincide, set wins.
- **Arbitration.** Combinational, per cycle.
  - Eligible: D = pend_valid; C = cpu_req & ~cpu_halted.
  - D only: debug wins. C only: CPU wins.
  - Both: the side not recorded in last_owner wins. last_owner updates on every issue.
- **CPU win.** cpu_gnt=1; mem_* driven from the cpu_* inputs.
- **Debug win.** mem_* driven from the pending entry; pend_valid clears at the clock edge.
- **Debug range check.** If dbg_addr[31:AW+2] is nonzero, the access is out of range.
  - It still wins arbitration and clears pend_valid, but mem_ce stays 0.
  - A read returns dbg_rdata=0 with normal latency.
  - A write is discarded.
- **CPU range.** CPU addresses are not range-checked; upper bits are ignored.
- **Idle.** mem_ce=0; mem_we=0. mem_addr and mem_wdata hold their last values.
- **Read return.** Read data is passed through combinationally from mem_rdata. It goes to dbg_rdata or cpu_rdata according to a registered owner tag.
- **dbg_busy.** Equals pend_valid.

## Timing
- **Reset values.**
  - Outputs: dbg_rdata_ready=0, dbg_overflow=0, cpu_rvalid=0, cpu_gnt=0, mem_ce=0, mem_we=0, dbg_busy=0. Other data outputs read 0.
  - Internal: pend_valid=0; last_owner=CPU, so debug wins the first contention.
- **Reset mid-operation.** A pending entry and any in-flight read return are discarded; no ready or valid pulse follows.
- **CPU latency.** cpu_gnt in the same cycle as cpu_req when it wins. For a read, cpu_rvalid=1 in cycle t+1 with cpu_rdata=mem_rdata. A write produces no rvalid.
- **CPU handshake.** The CPU must hold its request fields stable until cpu_gnt is high.
- **Debug latency.** dbg_ce in cycle t; issue no earlier than t+1. A read's dbg_rdata_ready pulses exactly one cycle after issue (earliest t+2), for one cycle.
- **Worst-case debug wait.** With continuous CPU requests, one CPU grant: issue by t+2, data by t+3.
- **Output validity.** cpu_rdata and dbg_rdata are don't-care outside their valid/ready cycles; the bench masks them.
- **Throughput.** One memory access per cycle, no bubbles, when both sides alternate.

## Structure
- **Shared package debug_mem_pkg.**
  - owner_t enum {OWN_CPU, OWN_DBG}.
  - Default AW.
  - Read-latency constant, fixed at 1.
- **Sub-module debug_req_buffer.** Holds the one-entry pending register and the overflow logic. Ports: strobe, issue, clr in; pend_valid, entry, overflow out.
- **Top level.** Arbitration, last_owner, range check and the read-return tag stay in the top level.

## Test plan
- **Debug write then read.**
  - Stimulus: cpu_req=0; dbg_ce write at addr 0x10, data 0xDEADBEEF; later a dbg_ce read at 0x10.
  - Required: mem_we at t+1 with mem_addr=4; dbg_rdata_ready at read t+2 with dbg_rdata=0xDEADBEEF.
- **Contention.**
  - Stimulus: cpu_req held high (reads of 0x0, 0x4, ...); dbg_ce read injected.
  - Required: debug wins the first contention after reset; the next contention goes to the CPU; exact alternation; cpu_rvalid lags cpu_gnt by one.
- **Overflow.**
  - Stimulus: cpu_halted=0; cpu_req high with last_owner=DBG; two dbg_ce strobes on consecutive cycles.
  - Required: second strobe latched only if the first issued that cycle, otherwise dbg_overflow=1; dbg_ovf_clr clears it; simultaneous set and clear leaves it 1.
- **Halt.**
  - Stimulus: cpu_halted=1 with cpu_req=1.
  - Required: cpu_gnt stays 0; a debug read completes in 2 cycles.
- **Out of range.**
  - Stimulus: dbg read at 0x0001_0000 with AW=12.
  - Required: mem_ce=0; dbg_rdata_ready one cycle later with data 0.
  - Stimulus: dbg write to the same address.
  - Required: no mem_we.
- **Mid-read reset.**
  - Stimulus: sys_rstn asserted the cycle after a debug read issues.
  - Required: no dbg_rdata_ready; dbg_busy=0; the next contention goes to debug.

Source files
------------

// File: rtl/debug_mem_pkg.sv
// Shared types and constants for the debug/CPU memory arbiter.
package debug_mem_pkg;

  localparam int unsigned AW_DEFAULT = 12;
  localparam int unsigned RD_LATENCY = 1;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dbg_entry_t;

endpackage

// File: rtl/debug_mem_arbiter_buffer.sv
// One-entry holding register for debug strobes, with sticky drop detection.
module debug_req_buffer
  import debug_mem_pkg::*;
(
  input  logic       cpu_clk,
  input  logic       sys_rstn,
  input  logic       strobe,
  input  dbg_entry_t din,
  input  logic       issue,
  input  logic       clr,
  output logic       pend_valid,
  output dbg_entry_t entry,
  output logic       overflow
);

  logic       pend_valid_q, pend_valid_d;
  logic       overflow_q, overflow_d;
  dbg_entry_t entry_q, entry_d;
  logic       accept;

  always_comb begin
    // A slot frees up in the same cycle the held entry issues.
    accept       = strobe & (~pend_valid_q | issue);
    pend_valid_d = pend_valid_q;
    entry_d      = entry_q;
    overflow_d   = overflow_q;
    if (accept) begin
      pend_valid_d = 1'b1;
      entry_d      = din;
    end else if (issue) begin
      pend_valid_d = 1'b0;
    end
    if (strobe & ~accept) begin
      overflow_d = 1'b1;
    end else if (clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      pend_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      entry_q      <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      overflow_q   <= overflow_d;
      entry_q      <= entry_d;
    end
  end

  assign pend_valid = pend_valid_q;
  assign entry      = entry_q;
  assign overflow   = overflow_q;

endmodule

// File: rtl/debug_mem_arbiter.sv
// Round-robin sharing of one single-port memory between CPU and debug accesses.
module debug_mem_arbiter
  import debug_mem_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic          cpu_clk,
  input  logic          sys_rstn,
  input  logic          dbg_ce,
  input  logic          dbg_we,
  input  logic [31:0]   dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic [31:0]   dbg_rdata,
  output logic          dbg_rdata_ready,
  output logic          dbg_overflow,
  input  logic          dbg_ovf_clr,
  output logic          dbg_busy,
  input  logic          cpu_halted,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_gnt,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_rvalid,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  dbg_entry_t din, pend_entry;
  logic       pend_valid;
  logic       cpu_elig, dbg_win, cpu_win, dbg_in_range, dbg_live;
  owner_t     last_owner_q, last_owner_d;
  owner_t     rd_tag_q, rd_tag_d;
  logic       rd_valid_q, rd_valid_d;
  logic       rd_oor_q, rd_oor_d;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          unused_addr_bits;

  assign din = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};

  debug_req_buffer u_buf (
    .cpu_clk    (cpu_clk),
    .sys_rstn   (sys_rstn),
    .strobe     (dbg_ce),
    .din        (din),
    .issue      (dbg_win),
    .clr        (dbg_ovf_clr),
    .pend_valid (pend_valid),
    .entry      (pend_entry),
    .overflow   (dbg_overflow)
  );

  assign cpu_elig         = cpu_req & ~cpu_halted;
  assign dbg_in_range     = (pend_entry.addr >> (AW + 2)) == '0;
  assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0], pend_entry.addr[1:0]};

  always_comb begin
    dbg_win      = pend_valid & (~cpu_elig | (last_owner_q == OWN_CPU));
    cpu_win      = cpu_elig & ~dbg_win;
    // Out-of-range debug accesses win a slot but never touch the macro.
    dbg_live     = dbg_win & dbg_in_range;
    mem_ce       = cpu_win | dbg_live;
    mem_we       = 1'b0;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    last_owner_d = last_owner_q;
    rd_valid_d   = 1'b0;
    rd_tag_d     = OWN_CPU;
    rd_oor_d     = 1'b0;
    if (cpu_win) begin
      mem_we       = cpu_we;
      mem_addr     = cpu_addr[AW+1:2];
      mem_wdata    = cpu_wdata;
      last_owner_d = OWN_CPU;
      rd_valid_d   = ~cpu_we;
    end else if (dbg_win) begin
      if (dbg_live) begin
        mem_we    = pend_entry.we;
        mem_addr  = pend_entry.addr[AW+1:2];
        mem_wdata = pend_entry.wdata;
      end
      last_owner_d = OWN_DBG;
      rd_valid_d   = ~pend_entry.we;
      rd_tag_d     = OWN_DBG;
      rd_oor_d     = ~dbg_in_range;
    end
  end

  always_ff @(posedge cpu_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      last_owner_q <= OWN_CPU;
      rd_valid_q   <= 1'b0;
      rd_tag_q     <= OWN_CPU;
      rd_oor_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      rd_valid_q   <= rd_valid_d;
      rd_tag_q     <= rd_tag_d;
      rd_oor_q     <= rd_oor_d;
      if (mem_ce) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
    end
  end

  assign cpu_gnt         = cpu_win;
  assign dbg_busy        = pend_valid;
  assign cpu_rvalid      = rd_valid_q & (rd_tag_q == OWN_CPU);
  assign dbg_rdata_ready = rd_valid_q & (rd_tag_q == OWN_DBG);
  assign cpu_rdata       = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata       = (dbg_rdata_ready & ~rd_oor_q) ? mem_rdata : '0;

endmodule
